// File: rtl/tft_pkg.sv
// Shared types for the TFT sequencer and the SPI word transmitter.
package tft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } tx_state_e;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam int WORD_W      = 9;
   localparam int DC_POS      = 8;
   localparam int PAYLOAD_MSB = 7;

   // D/C flag in bit 8, payload in bits 7:0 (sent MSB first)
   typedef struct packed {
      logic       dc;
      logic [7:0] payload;
   } tft_word_t;

   function automatic tft_word_t make_word(input logic dc, input logic [7:0] payload);
      tft_word_t w;
      w.dc      = dc;
      w.payload = payload;
      return w;
   endfunction

endpackage

// File: rtl/spi_tft_tx_if.sv
// Request handshake between the TFT sequencer (master) and the transmitter (slave).
interface spi_tft_tx_if;
   import tft_pkg::*;

   tft_word_t data_in;
   logic      data_set;
   logic      idle;

   modport master (output data_in, output data_set, input idle);
   modport slave  (input data_in, input data_set, output idle);

endinterface

// File: rtl/spi_tft_tx.sv
// SPI mode-0 transmitter for one 9-bit TFT word: 8 payload bits on sdi plus a D/C line.
// Every pin is a flop output; the next value of each is computed in one combinational block.
//
// state | meaning
// IDLE  | waiting for data_set, cs high, idle high
// LOW   | sck low for CLK_DIV cycles, sdi holds the current bit
// HIGH  | sck high for CLK_DIV cycles, panel has sampled sdi
// DONE  | cs hold time after the last bit, sck low
module spi_tft_tx
   import tft_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic         clk,
   input  logic         rst,
   spi_tft_tx_if.slave  bus,
   output logic         sck,
   output logic         sdi,
   output logic         dc,
   output logic         cs
);

   localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             sck_q, sck_d;
   logic             sdi_q, sdi_d;
   logic             dc_q, dc_d;
   logic             cs_q, cs_d;
   logic             idle_q, idle_d;

   // Register file of the FSM: state, phase timer, bit index, shifter and all pins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sck_q   <= 1'b0;
         sdi_q   <= 1'b0;
         dc_q    <= 1'b0;
         cs_q    <= 1'b1;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sck_q   <= sck_d;
         sdi_q   <= sdi_d;
         dc_q    <= dc_d;
         cs_q    <= cs_d;
         idle_q  <= idle_d;
      end
   end

   // Next-state and next-pin logic; the phase timer counts down and acts at zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sck_d   = sck_q;
      sdi_d   = sdi_q;
      dc_d    = dc_q;
      cs_d    = cs_q;
      idle_d  = idle_q;

      case (state_q)
         IDLE: begin
            if (bus.data_set) begin
               shreg_d = bus.data_in.payload;
               dc_d    = bus.data_in.dc;
               sdi_d   = bus.data_in.payload[PAYLOAD_MSB];
               cs_d    = 1'b0;
               idle_d  = 1'b0;
               bit_d   = 3'd7;
               cnt_d   = CNT_LOAD;
               state_d = LOW;
            end
         end
         LOW: begin
            if (cnt_q == '0) begin
               sck_d   = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               sck_d = 1'b0;
               cnt_d = CNT_LOAD;
               if (bit_q != 3'd0) begin
                  // sdi moves on the same edge sck falls, so it never changes while sck is high
                  bit_d   = bit_q - 3'd1;
                  shreg_d = {shreg_q[6:0], 1'b0};
                  sdi_d   = shreg_q[6];
                  state_d = LOW;
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (cnt_q == '0) begin
               cs_d    = 1'b1;
               idle_d  = 1'b1;
               sdi_d   = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sck      = sck_q;
   assign sdi      = sdi_q;
   assign dc       = dc_q;
   assign cs       = cs_q;
   assign bus.idle = idle_q;

endmodule

// File: tb/tb_spi_tft_tx.sv
// Scoreboard bench for spi_tft_tx: DUT0 at CLK_DIV=2, DUT1 at CLK_DIV=1.
module tb_spi_tft_tx;
   import tft_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_tft_tx_if bus0 ();
   spi_tft_tx_if bus1 ();

   logic [1:0] sck_w, sdi_w, dc_w, cs_w;
   logic [1:0] idle_w;
   assign idle_w = {bus1.idle, bus0.idle};

   spi_tft_tx #(.CLK_DIV(2)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0),
      .sck (sck_w[0]), .sdi (sdi_w[0]), .dc (dc_w[0]), .cs (cs_w[0])
   );

   spi_tft_tx #(.CLK_DIV(1)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1),
      .sck (sck_w[1]), .sdi (sdi_w[1]), .dc (dc_w[1]), .cs (cs_w[1])
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dc;
      logic [7:0] payload;
      int         gap;
   } exp_t;

   exp_t exp_q [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-DUT frame monitor: collects one frame per cs-low window and checks it against the queue head
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int DIV = (g == 0) ? 2 : 1;
      logic       active = 1'b0;
      logic       prev_sck = 1'b0;
      logic       prev_sdi = 1'b0;
      logic       dc0 = 1'b0;
      logic       last_dc = 1'b0;
      logic       have_last = 1'b0;
      logic [7:0] bits = 8'h00;
      int         nrise = 0, cslow = 0, idlelow = 0;
      int         period_bad = 0, dc_bad = 0, sdi_bad = 0, dcgap_bad = 0;
      int         gap_cnt = 0, gap_at_start = 0, cyc = 0, last_rise = -1;
      int         frames = 0;
      exp_t       e;

      always @(negedge clk) begin
         if (rst) begin
            active    = 1'b0;
            have_last = 1'b0;
            gap_cnt   = 0;
         end else begin
            if (!active && cs_w[g] == 1'b0) begin
               active       = 1'b1;
               bits         = 8'h00;
               nrise        = 0;
               cslow        = 0;
               idlelow      = 0;
               period_bad   = 0;
               dc_bad       = 0;
               sdi_bad      = 0;
               last_rise    = -1;
               dc0          = dc_w[g];
               gap_at_start = gap_cnt;
            end
            if (active) begin
               if (cs_w[g] == 1'b0) begin
                  cslow++;
                  if (!idle_w[g]) idlelow++;
                  if (dc_w[g] != dc0) dc_bad++;
                  if (sdi_w[g] != prev_sdi && sck_w[g]) sdi_bad++;
                  if (sck_w[g] && !prev_sck) begin
                     bits = {bits[6:0], sdi_w[g]};
                     nrise++;
                     if (last_rise >= 0 && (cyc - last_rise) != 2 * DIV) period_bad++;
                     last_rise = cyc;
                  end
               end else begin
                  if (exp_q[g].size() == 0) begin
                     chk($sformatf("unexpected_frame_dut%0d", g), 1, 0);
                  end else begin
                     e = exp_q[g].pop_front();
                     chk($sformatf("payload_dut%0d", g), int'(bits), int'(e.payload));
                     chk($sformatf("dc_dut%0d", g), int'(dc0), int'(e.dc));
                     chk($sformatf("cs_low_cycles_dut%0d", g), cslow, 17 * DIV);
                     chk($sformatf("idle_low_cycles_dut%0d", g), idlelow, 17 * DIV);
                     chk($sformatf("sck_rises_dut%0d", g), nrise, 8);
                     chk($sformatf("sck_period_errs_dut%0d", g), period_bad, 0);
                     chk($sformatf("dc_unstable_dut%0d", g), dc_bad, 0);
                     chk($sformatf("sdi_change_sck_high_dut%0d", g), sdi_bad, 0);
                     chk($sformatf("dc_change_between_dut%0d", g), dcgap_bad, 0);
                     if (e.gap >= 0) chk($sformatf("cs_gap_dut%0d", g), gap_at_start, e.gap);
                  end
                  dcgap_bad = 0;
                  frames++;
                  last_dc   = dc0;
                  have_last = 1'b1;
                  active    = 1'b0;
                  gap_cnt   = 1;
               end
            end else begin
               gap_cnt++;
               if (have_last && dc_w[g] != last_dc) dcgap_bad++;
            end
         end
         prev_sck = sck_w[g];
         prev_sdi = sdi_w[g];
         cyc++;
      end
   end

   task automatic drive(input int d, input logic [8:0] w, input logic set);
      if (d == 0) begin
         bus0.data_in  = tft_word_t'(w);
         bus0.data_set = set;
      end else begin
         bus1.data_in  = tft_word_t'(w);
         bus1.data_set = set;
      end
   endtask

   // Waits for idle, pushes the expected frame, strobes data_set for one cycle, then scrambles data_in
   task automatic send(input int d, input logic [8:0] w, input bit push, input int gap);
      int   k;
      exp_t x;
      k = 0;
      while (!idle_w[d] && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!idle_w[d]) chk($sformatf("idle_wait_timeout_dut%0d", d), 0, 1);
      if (push) begin
         x.dc      = w[8];
         x.payload = w[7:0];
         x.gap     = gap;
         exp_q[d].push_back(x);
      end
      drive(d, w, 1'b1);
      @(negedge clk);
      drive(d, ~w, 1'b0);
   endtask

   initial begin
      int   n, k;
      logic p;
      drive(0, 9'h000, 1'b0);
      drive(1, 9'h000, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_cs", int'(cs_w[0]), 1);
      chk("reset_idle", int'(idle_w[0]), 1);
      chk("reset_sck", int'(sck_w[0]), 0);
      chk("reset_dc", int'(dc_w[0]), 0);
      chk("reset_sdi", int'(sdi_w[0]), 0);

      // abandon a data word after three sck rising edges
      send(0, 9'h1A5, 1'b0, -1);
      n = 0;
      k = 0;
      p = sck_w[0];
      while (n < 3 && k < 200) begin
         @(negedge clk);
         k++;
         if (sck_w[0] && !p) n++;
         p = sck_w[0];
      end
      if (n < 3) chk("reset_wait_timeout", n, 3);
      #2 rst = 1'b1;
      #1;
      chk("midrst_sck", int'(sck_w[0]), 0);
      chk("midrst_cs", int'(cs_w[0]), 1);
      chk("midrst_idle", int'(idle_w[0]), 1);
      chk("midrst_dc", int'(dc_w[0]), 0);
      chk("midrst_sdi", int'(sdi_w[0]), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      p = sck_w[0];
      repeat (20) begin
         @(negedge clk);
         if (sck_w[0] && !p) n++;
         p = sck_w[0];
      end
      chk("sck_edges_after_reset", n, 0);

      send(0, 9'h011, 1'b1, -1);
      send(0, 9'h1A5, 1'b1, -1);
      send(0, 9'h02C, 1'b1, -1);
      repeat (6) @(negedge clk);
      drive(0, 9'h1FF, 1'b1);
      @(negedge clk);
      drive(0, 9'h1FF, 1'b0);
      send(0, 9'h02A, 1'b1, -1);
      send(0, 9'h100, 1'b1, 1);
      send(1, 9'h0FF, 1'b1, -1);

      k = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || !idle_w[0] || !idle_w[1]) && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      chk("pending_dut0", exp_q[0].size(), 0);
      chk("pending_dut1", exp_q[1].size(), 0);
      chk("frames_dut0", g_mon[0].frames, 5);
      chk("frames_dut1", g_mon[1].frames, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_tft_tx.md
Name: spi_tft_tx

Overview:
- Serial transmitter that sends one 9-bit word to a 4-wire SPI TFT controller (ILI9341-class): 8 bits on SDI, plus a separate D/C line.
- Sits between the TFT init/pixel sequencer and the panel pins. The sequencer pulses data_set while idle is high, then waits for idle again before sending the next word.
- Write-only: the panel's SDO is not used.

Parameters:
- CLK_DIV, default 2: number of clk cycles per SCK half-period; must be ≥1. SCK frequency = clk / (2·CLK_DIV), so 25 MHz at a 100 MHz clk.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  9  word to send. Bit 8 is the D/C flag (1 = data/parameter, 0 = command). Bits 7:0 are the payload, sent MSB first.
- data_set  in  1  one-cycle request strobe; accepted only while idle = 1.
- sck  out  1  SPI clock, idle low (mode 0).
- sdi  out  1  serial data to the panel (MOSI).
- dc  out  1  data/command select; equals the latched data_in[8].
- cs  out  1  chip select, active low.
- idle  out  1  high when ready to accept a word.

Behaviour:
- Reset (async, any time, including mid-transfer): sck=0, sdi=0, dc=0, cs=1, idle=1; shift register and counters cleared. An in-progress transfer is abandoned with no completion.
- States: IDLE, LOW, HIGH, DONE. A single down-counter of width clog2(CLK_DIV)+1 times each phase; a 3-bit counter indexes the bit.
- IDLE: idle=1, cs=1, sck=0.
  - Accept condition: data_set=1 at a clk edge.
  - Registered at that same edge: shift register ← data_in[7:0], dc ← data_in[8], sdi ← data_in[7], cs ← 0, idle ← 0; next state LOW with bit index 7.
  - idle is therefore low from the cycle after acceptance, so the requester never sees idle=1 while its own strobe is still in flight.
- LOW: sck=0 for CLK_DIV cycles, then sck ← 1 and state → HIGH. The panel samples sdi on this rising edge.
- HIGH: sck=1 for CLK_DIV cycles, then sck ← 0.
  - If bit index > 0: decrement the index, sdi ← next lower payload bit, state → LOW.
  - If bit index = 0: state → DONE.
- DONE: cs held low with sck=0 for CLK_DIV cycles (CS hold time). Then cs ← 1, idle ← 1, sdi ← 0, state → IDLE.
- Output stability:
  - dc is stable for the whole time cs is low and keeps its value after the transfer until the next acceptance.
  - sdi changes only while sck is low.
- Timing:
  - Acceptance edge to idle rising = 17·CLK_DIV clk cycles (34 at default).
  - Exactly 8 sck rising edges per word.
- Strobes and data changes:
  - data_set while idle=0 is ignored and not queued.
  - data_in is sampled only at acceptance; later changes do not affect the word in flight.
- Back-to-back: a data_set arriving in the same cycle idle returns high is accepted. cs goes high for at least one clk cycle between words.
- No glitches: sck, sdi, dc, cs and idle are all driven directly from flops.

Decomposition:
- Shared package tft_pkg:
  - state enum (IDLE/LOW/HIGH/DONE);
  - constants DC_CMD=0 and DC_DATA=1;
  - 9-bit word type with field positions (DC bit 8, payload 7:0), shared with the TFT sequencer.
- No sub-module required: one FSM with a phase counter and a shift register.

Test Plan:
- Reset: assert rst mid-transfer (e.g. after 3 sck rising edges) -> sck=0, cs=1, idle=1, dc=0, sdi=0 immediately. No further sck edges until a new data_set.
- Command word: data_set with data_in=9'h011 at CLK_DIV=2 -> dc=0 while cs low; sdi sampled on the 8 sck rising edges = 0,0,0,1,0,0,0,1; idle returns exactly 34 cycles after the acceptance edge.
- Data word: data_in=9'h1A5 -> dc=1; bits 1,0,1,0,0,1,0,1; sck period = 4 clk cycles; cs low for 34 cycles.
- Busy strobe: data_set with 9'h1FF while busy sending 9'h02C -> it is ignored; only the 8 bits 00101100 are shifted, and idle returns at 34 cycles.
- Back-to-back: words 9'h02A then 9'h100 issued the cycle idle rises -> two complete frames, cs high for at least 1 cycle between them; dc changes from 0 to 1 only at the second acceptance.
- Divider: CLK_DIV=1 with 9'h0FF -> sck period = 2 clk cycles, eight 1s on sdi, total busy time 17 cycles.
